ysyx_25020032_imm_stage: RTL

Registered, parametrised immediate-generation stage between IFU and IDU. It accepts fetched instructions over a valid/ready handshake and derives the immediate format from the opcode, so no external type select is needed. It produces the XLEN-wide sign- or zero-extended immediate and holds it in a 2-entry skid buffer, which sustains one instruction per cycle under back-pressure. It generalises the combinational extender: 64-bit support, 6-bit RV64 shift amounts, CSR zimm, pipeline flush.

---
 rtl/ysyx_25020032_imm_stage_pkg.sv | 34 +++
 rtl/ysyx_25020032_imm_stage_if.sv | 33 +++
 rtl/ysyx_25020032_imm_dec.sv | 100 ++++++++++
 rtl/ysyx_25020032_imm_stage.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ysyx_25020032_imm_stage_pkg.sv
// Shared types and constants for the immediate-generation stage.
//   instr_type_e : immediate format of a decoded instruction
//   buf_state_e  : occupancy of the 2-entry skid buffer
//   Opc*         : RV32/RV64 major opcodes used by the decoder
package ysyx_25020032_imm_stage_pkg;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmU = 3'd1,
    ImmJ = 3'd2,
    ImmS = 3'd3,
    ImmB = 3'd4,
    ImmZ = 3'd5,
    ImmN = 3'd7
  } instr_type_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

endpackage

// File: rtl/ysyx_25020032_imm_stage_if.sv
// Handshake bundle between IFU, the immediate stage and IDU.
//   in_valid/in_ready/in_instr/in_pc       : upstream side (IFU -> stage)
//   out_valid/out_ready/out_instr/out_pc   : downstream side (stage -> IDU)
//   out_imm/out_imm_type                   : decoded immediate of the head entry
// Modports: slave = the stage, master = the environment driving/consuming it.
interface ysyx_25020032_imm_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
);
  import ysyx_25020032_imm_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  instr_type_e       out_imm_type;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type
  );

endinterface

// File: rtl/ysyx_25020032_imm_dec.sv
// Combinational immediate decoder: derives the format from the opcode and
// builds the XLEN-wide extended immediate.
//   i_instr    : raw 32-bit instruction
//   o_imm_type : decoded immediate format
//   o_imm      : sign- or zero-extended immediate
// Optional feature: define YSYX_25020032_ZICSR_IMM_EN to decode CSR*I
// instructions (SYSTEM, funct3[2]=1) as Z type with the zimm in rs1.
module ysyx_25020032_imm_dec
  import ysyx_25020032_imm_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]      i_instr,
  output instr_type_e      o_imm_type,
  output logic [XLEN-1:0]  o_imm
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_raw;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];

  // Every format is first built as a 32-bit value; zero-extended forms keep
  // bit 31 clear, so a single sign extension from bit 31 covers all cases.
  always_comb begin
    o_imm_type = ImmN;
    w_raw      = 32'h0;
    case (w_opcode)
      OpcLui, OpcAuipc: begin
        o_imm_type = ImmU;
        w_raw      = {i_instr[31:12], 12'b0};
      end
      OpcJal: begin
        o_imm_type = ImmJ;
        w_raw      = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      end
      OpcJalr, OpcLoad: begin
        o_imm_type = ImmI;
        w_raw      = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OpcOpImm: begin
        o_imm_type = ImmI;
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          // Shifts: RV64 carries a 6-bit shamt, RV32 a 5-bit one.
          if (XLEN == 64) w_raw = {26'b0, i_instr[25:20]};
          else            w_raw = {27'b0, i_instr[24:20]};
        end else begin
          w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
        end
      end
      OpcOpImm32: begin
        // Word ops only exist on RV64; on RV32 the opcode is unknown.
        if (XLEN == 64) begin
          o_imm_type = ImmI;
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            w_raw = {27'b0, i_instr[24:20]};
          end else begin
            w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
          end
        end
      end
      OpcStore: begin
        o_imm_type = ImmS;
        w_raw      = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OpcBranch: begin
        o_imm_type = ImmB;
        w_raw      = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      end
      OpcSystem: begin
`ifdef YSYX_25020032_ZICSR_IMM_EN
        if (w_funct3[2]) begin
          o_imm_type = ImmZ;
          w_raw      = {27'b0, i_instr[19:15]};
        end else begin
          o_imm_type = ImmI;
          w_raw      = {{20{i_instr[31]}}, i_instr[31:20]};
        end
`else
        o_imm_type = ImmI;
        w_raw      = {{20{i_instr[31]}}, i_instr[31:20]};
`endif
      end
      default: begin
        o_imm_type = ImmN;
        w_raw      = 32'h0;
      end
    endcase
  end

  always_comb begin
    o_imm       = {XLEN{w_raw[31]}};
    o_imm[31:0] = w_raw;
  end

endmodule

// File: rtl/ysyx_25020032_imm_stage.sv
// Registered immediate-generation stage between IFU and IDU. Decodes the
// incoming instruction and holds {instr, pc, imm, type} in a 2-entry skid
// buffer so one instruction per cycle is sustained under back-pressure.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, discards all entries
//   i_flush : drop every buffered entry and any same-cycle push
//   bus     : slave side of the in/out valid-ready handshake
// Optional feature: YSYX_25020032_ZICSR_IMM_EN (see ysyx_25020032_imm_dec).
module ysyx_25020032_imm_stage
  import ysyx_25020032_imm_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  ysyx_25020032_imm_stage_if.slave    bus
);

  buf_state_e        r_cnt;
  logic              r_in_ready;

  logic [31:0]       r_head_instr;
  logic [PC_W-1:0]   r_head_pc;
  logic [XLEN-1:0]   r_head_imm;
  instr_type_e       r_head_type;

  logic [31:0]       r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc;
  logic [XLEN-1:0]   r_skid_imm;
  instr_type_e       r_skid_type;

  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic [XLEN-1:0]   w_dec_imm;
  instr_type_e       w_dec_type;

  ysyx_25020032_imm_dec #(
    .XLEN (XLEN)
  ) u_dec (
    .i_instr    (bus.in_instr),
    .o_imm_type (w_dec_type),
    .o_imm      (w_dec_imm)
  );

  assign w_out_valid = (r_cnt != StEmpty);
  assign w_push      = bus.in_valid & r_in_ready & ~i_flush;
  assign w_pop       = w_out_valid & bus.out_ready & ~i_flush;

  // r_in_ready mirrors (next r_cnt != StFull) so out_ready never reaches
  // in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= StEmpty;
      r_in_ready   <= 1'b1;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_head_imm   <= '0;
      r_head_type  <= ImmN;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_imm   <= '0;
      r_skid_type  <= ImmN;
    end else if (i_flush) begin
      r_cnt      <= StEmpty;
      r_in_ready <= 1'b1;
    end else begin
      case (r_cnt)
        StEmpty: begin
          if (w_push) begin
            r_head_instr <= bus.in_instr;
            r_head_pc    <= bus.in_pc;
            r_head_imm   <= w_dec_imm;
            r_head_type  <= w_dec_type;
            r_cnt        <= StOne;
          end
        end
        StOne: begin
          case ({w_push, w_pop})
            2'b10: begin
              // Head is stalled: park the new entry behind it.
              r_skid_instr <= bus.in_instr;
              r_skid_pc    <= bus.in_pc;
              r_skid_imm   <= w_dec_imm;
              r_skid_type  <= w_dec_type;
              r_cnt        <= StFull;
              r_in_ready   <= 1'b0;
            end
            2'b01: begin
              r_cnt <= StEmpty;
            end
            2'b11: begin
              r_head_instr <= bus.in_instr;
              r_head_pc    <= bus.in_pc;
              r_head_imm   <= w_dec_imm;
              r_head_type  <= w_dec_type;
            end
            default: ;
          endcase
        end
        StFull: begin
          if (w_pop) begin
            r_head_instr <= r_skid_instr;
            r_head_pc    <= r_skid_pc;
            r_head_imm   <= r_skid_imm;
            r_head_type  <= r_skid_type;
            r_cnt        <= StOne;
            r_in_ready   <= 1'b1;
          end
        end
        default: begin
          r_cnt      <= StEmpty;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_instr    = r_head_instr;
  assign bus.out_pc       = r_head_pc;
  assign bus.out_imm      = r_head_imm;
  assign bus.out_imm_type = r_head_type;

endmodule
